// File: rtl/apb_slave_mem_ws.sv
// APB4 completer backed by a byte-addressed RAM window with programmable wait
// states and PSLVERR decoding of range, alignment, strobe and protection faults.
module apb_slave_mem_ws #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_BYTES   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0000_1000,
  parameter int                    WAIT_STATES = 0,
  parameter bit                    SECURE_ONLY = 1'b0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [2:0]              PPROT,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int DEPTH = MEM_BYTES / LANES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(MEM_BYTES);

  // The setup phase is the bus cycle with PSEL & !PENABLE; its closing edge
  // captures the request and moves straight into ACCESS.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic                 write_reg;
  logic                 err_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [LANES-1:0]     strb_reg;

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  req_err;
  logic                  setup_fire;
  logic                  access_done;
  logic                  mem_we;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_prot;

  assign offset     = PADDR - BASE_ADDR;
  assign idx        = offset[LSB +: IDX_W];
  assign setup_fire = PSEL && !PENABLE;

  assign req_err = (PADDR < BASE_ADDR) || (offset >= WINDOW)
                 || (|PADDR[LSB-1:0])
                 || (!PWRITE && (|PSTRB))
                 || (SECURE_ONLY && PPROT[1]);
  assign unused_prot = PPROT[2] ^ PPROT[0];

  assign access_done = (state_reg == ACCESS) && (cnt_reg == 4'd0);
  assign mem_we      = access_done && PSEL && PENABLE && write_reg && !err_reg;
  // Faulting requests never touch the array.
  assign rd_en       = setup_fire && !PWRITE && !req_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      strb_reg  <= '0;
    end else if (setup_fire) begin
      state_reg <= ACCESS;
      cnt_reg   <= 4'(WAIT_STATES);
      write_reg <= PWRITE;
      err_reg   <= req_err;
      idx_reg   <= idx;
      strb_reg  <= PSTRB;
    end else if (state_reg == ACCESS) begin
      if (!PSEL) begin
        // Select dropped mid-access: abandon the transfer without writing.
        state_reg <= IDLE;
        cnt_reg   <= 4'd0;
      end else if (cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end else begin
        state_reg <= IDLE;
      end
    end else begin
      state_reg <= IDLE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge PCLK) begin
        if (mem_we && strb_reg[gi])
          ram[idx_reg] <= PWDATA[8*gi +: 8];
        if (rd_en)
          rd_q <= ram[idx];
      end

      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign PREADY  = access_done;
  assign PSLVERR = access_done && err_reg;
  assign PRDATA  = (access_done && !write_reg && !err_reg) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// Three completer configurations (zero-wait, 3-wait secure-only, 64-bit 1-wait)
// exercised by directed and random transfers against a byte-level memory model.
module tb_apb_slave_mem_ws;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel_v;
  logic        penable, pwrite;
  logic [2:0]  pprot;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;

  logic [31:0] prdata_a, prdata_b;
  logic [63:0] prdata_c;
  logic        pready_a, pready_b, pready_c;
  logic        pslverr_a, pslverr_b, pslverr_c;

  int          cur;
  logic [63:0] rd_m;
  logic        rdy_m, err_m;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mdl [int];

  always #5 pclk = ~pclk;

  apb_slave_mem_ws #(.WAIT_STATES(0)) u_a (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_v[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata[31:0]),
    .PSTRB(pstrb[3:0]), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

  apb_slave_mem_ws #(.WAIT_STATES(3), .SECURE_ONLY(1'b1)) u_b (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_v[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata[31:0]),
    .PSTRB(pstrb[3:0]), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

  apb_slave_mem_ws #(.DATA_WIDTH(64), .WAIT_STATES(1)) u_c (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel_v[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PPROT(pprot), .PADDR(paddr), .PWDATA(pwdata),
    .PSTRB(pstrb), .PRDATA(prdata_c), .PREADY(pready_c), .PSLVERR(pslverr_c));

  assign rd_m  = (cur == 0) ? {32'b0, prdata_a} : (cur == 1) ? {32'b0, prdata_b} : prdata_c;
  assign rdy_m = (cur == 0) ? pready_a  : (cur == 1) ? pready_b  : pready_c;
  assign err_m = (cur == 0) ? pslverr_a : (cur == 1) ? pslverr_b : pslverr_c;

  function automatic int nbytes(input int t);
    return (t == 2) ? 8 : 4;
  endfunction

  function automatic int wsof(input int t);
    return (t == 0) ? 0 : (t == 1) ? 3 : 1;
  endfunction

  // Reference: error rules and byte-array memory, independent of any FSM.
  task automatic ref_model(input int t, input bit wr, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [7:0] st, input logic [2:0] pr,
                           output bit e_err, output logic [63:0] e_rd, output bit e_known);
    int nb;
    int base;
    logic [7:0] mask;
    nb   = nbytes(t);
    mask = (nb == 8) ? 8'hFF : 8'h0F;
    base = t * 'h10000 + int'(addr);
    e_err = (addr < 32'h1000) || (addr >= 32'h2000) || ((addr % nb) != 0)
          || (!wr && ((st & mask) != 0)) || (t == 1 && pr[1]);
    e_rd = '0;
    e_known = 1'b1;
    if (!e_err) begin
      for (int i = 0; i < nb; i++) begin
        if (wr) begin
          if (st[i]) mdl[base + i] = wd[8*i +: 8];
        end else if (mdl.exists(base + i)) begin
          e_rd[8*i +: 8] = mdl[base + i];
        end else begin
          e_known = 1'b0;
        end
      end
    end
  endtask

  // One APB transfer; starts and ends 1 time unit after a rising edge.
  task automatic xfer(input int t, input bit wr, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] st, input logic [2:0] pr,
                      output logic [63:0] rd, output logic err, output int lat, output int bad);
    cur = t;
    psel_v = 3'b000;
    psel_v[t] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st; pprot = pr;
    lat = 1; bad = 0;
    @(posedge pclk); #1;
    penable = 1'b1;
    lat = 2;
    while (!rdy_m && lat < 40) begin
      if (err_m !== 1'b0 || rd_m !== 64'd0) bad++;
      @(posedge pclk); #1;
      lat++;
    end
    rd  = rd_m;
    err = err_m;
    if (!rdy_m) lat = -1;
    $display("xfer t=%0d %s addr=%h wdata=%h strb=%h prot=%b -> rdata=%h slverr=%0d cycles=%0d",
             t, wr ? "WR" : "RD", addr, wd, st, pr, rd, err, lat);
    @(posedge pclk); #1;
  endtask

  task automatic bus_idle();
    psel_v = 3'b000;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    bus_idle();
    pwrite = 0; pprot = 0; paddr = 0; pwdata = 0; pstrb = 0;
    repeat (3) @(posedge pclk);
    #1;
    for (int t = 0; t < 3; t++) begin
      cur = t;
      #0;
      n_checks++; if (rdy_m !== 1'b0) $display("FAIL reset_pready t=%0d: got %b expected 0", t, rdy_m); else n_pass++;
      n_checks++; if (err_m !== 1'b0) $display("FAIL reset_pslverr t=%0d: got %b expected 0", t, err_m); else n_pass++;
      n_checks++; if (rd_m !== 64'd0) $display("FAIL reset_prdata t=%0d: got %h expected 0", t, rd_m); else n_pass++;
    end
    presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_basic();
    logic [63:0] rd, e_rd; logic err; int lat, bad; bit e_err, e_known;
    ref_model(0, 1, 32'h1000, 64'hDEADBEEF, 8'hF, 3'b000, e_err, e_rd, e_known);
    xfer(0, 1, 32'h1000, 64'hDEADBEEF, 8'hF, 3'b000, rd, err, lat, bad);
    n_checks++; if (err !== 1'b0) $display("FAIL basic_wr_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL basic_wr_cycles: got %0d expected 2", lat); else n_pass++;
    ref_model(0, 0, 32'h1000, 64'd0, 8'h0, 3'b000, e_err, e_rd, e_known);
    xfer(0, 0, 32'h1000, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (err !== 1'b0) $display("FAIL basic_rd_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL basic_rd_cycles: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (rd !== 64'hDEADBEEF) $display("FAIL basic_rd_data: got %h expected deadbeef", rd); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_partial_strobe();
    logic [63:0] rd, e_rd; logic err; int lat, bad; bit e_err, e_known;
    ref_model(0, 1, 32'h1004, 64'h11223344, 8'hF, 3'b000, e_err, e_rd, e_known);
    xfer(0, 1, 32'h1004, 64'h11223344, 8'hF, 3'b000, rd, err, lat, bad);
    ref_model(0, 1, 32'h1004, 64'hAABBCCDD, 8'h5, 3'b000, e_err, e_rd, e_known);
    xfer(0, 1, 32'h1004, 64'hAABBCCDD, 8'h5, 3'b000, rd, err, lat, bad);
    ref_model(0, 0, 32'h1004, 64'd0, 8'h0, 3'b000, e_err, e_rd, e_known);
    xfer(0, 0, 32'h1004, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (rd !== 64'h11BB33DD) $display("FAIL partial_rd_data: got %h expected 11bb33dd", rd); else n_pass++;
    n_checks++; if (rd !== e_rd) $display("FAIL partial_model: got %h expected %h", rd, e_rd); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_wait_states();
    logic [63:0] rd, e_rd; logic err; int lat, bad; bit e_err, e_known;
    ref_model(1, 1, 32'h1FFC, 64'hCAFEF00D, 8'hF, 3'b000, e_err, e_rd, e_known);
    xfer(1, 1, 32'h1FFC, 64'hCAFEF00D, 8'hF, 3'b000, rd, err, lat, bad);
    n_checks++; if (lat != 5) $display("FAIL wait_wr_cycles: got %0d expected 5", lat); else n_pass++;
    ref_model(1, 0, 32'h1FFC, 64'd0, 8'h0, 3'b000, e_err, e_rd, e_known);
    xfer(1, 0, 32'h1FFC, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (lat != 5) $display("FAIL wait_rd_cycles: got %0d expected 5", lat); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL wait_low_outputs: got %0d nonzero wait cycles expected 0", bad); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL wait_rd_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (rd !== 64'hCAFEF00D) $display("FAIL wait_rd_data: got %h expected cafef00d", rd); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_errors();
    logic [63:0] rd, e_rd; logic err; int lat, bad; bit e_err, e_known;
    xfer(0, 0, 32'h2000, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    n_checks++; if (err !== 1'b1) $display("FAIL err_range_flag: got %b expected 1", err); else n_pass++;
    n_checks++; if (rd !== 64'd0) $display("FAIL err_range_data: got %h expected 0", rd); else n_pass++;
    xfer(0, 1, 32'h1002, 64'hFFFFFFFF, 8'hF, 3'b000, rd, err, lat, bad);
    n_checks++; if (err !== 1'b1) $display("FAIL err_misalign_flag: got %b expected 1", err); else n_pass++;
    xfer(0, 0, 32'h1000, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    n_checks++; if (rd !== 64'hDEADBEEF) $display("FAIL err_misalign_nowrite: got %h expected deadbeef", rd); else n_pass++;
    xfer(0, 0, 32'h1000, 64'd0, 8'h1, 3'b000, rd, err, lat, bad);
    n_checks++; if (err !== 1'b1) $display("FAIL err_rd_strobe_flag: got %b expected 1", err); else n_pass++;
    n_checks++; if (rd !== 64'd0) $display("FAIL err_rd_strobe_data: got %h expected 0", rd); else n_pass++;
    xfer(1, 1, 32'h1FFC, 64'h0, 8'hF, 3'b010, rd, err, lat, bad);
    n_checks++; if (err !== 1'b1) $display("FAIL err_secure_flag: got %b expected 1", err); else n_pass++;
    n_checks++; if (lat != 5) $display("FAIL err_secure_cycles: got %0d expected 5", lat); else n_pass++;
    xfer(1, 0, 32'h1FFC, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (rd !== 64'hCAFEF00D) $display("FAIL err_secure_nowrite: got %h expected cafef00d", rd); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_wide();
    logic [63:0] rd, e_rd; logic err; int lat, bad; bit e_err, e_known;
    ref_model(2, 1, 32'h1008, 64'hFFEEDDCCBBAA9988, 8'hFF, 3'b000, e_err, e_rd, e_known);
    xfer(2, 1, 32'h1008, 64'hFFEEDDCCBBAA9988, 8'hFF, 3'b000, rd, err, lat, bad);
    ref_model(2, 1, 32'h1008, 64'h0123456789ABCDEF, 8'hF0, 3'b000, e_err, e_rd, e_known);
    xfer(2, 1, 32'h1008, 64'h0123456789ABCDEF, 8'hF0, 3'b000, rd, err, lat, bad);
    n_checks++; if (lat != 3) $display("FAIL wide_wr_cycles: got %0d expected 3", lat); else n_pass++;
    xfer(2, 0, 32'h1008, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    n_checks++; if (rd !== 64'h01234567BBAA9988) $display("FAIL wide_rd_data: got %h expected 01234567bbaa9988", rd); else n_pass++;
    xfer(2, 0, 32'h1004, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (err !== 1'b1) $display("FAIL wide_misalign_flag: got %b expected 1", err); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd, e_rd; logic err; int lat, bad; bit e_err, e_known;
    ref_model(0, 1, 32'h1010, 64'h600DF00D, 8'hF, 3'b000, e_err, e_rd, e_known);
    xfer(0, 1, 32'h1010, 64'h600DF00D, 8'hF, 3'b000, rd, err, lat, bad);
    xfer(0, 0, 32'h1010, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (rd !== 64'h600DF00D) $display("FAIL b2b_rd_data: got %h expected 600df00d", rd); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL b2b_rd_cycles: got %0d expected 2", lat); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_abort();
    logic [63:0] rd; logic err; int lat, bad;
    cur = 1;
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1FFC;
    pwdata = 64'h0; pstrb = 8'hF; pprot = 3'b000;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel_v = 3'b000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      if (rdy_m !== 1'b0) bad++;
    end
    penable = 1'b0;
    n_checks++; if (bad != 0) $display("FAIL abort_pready: got %0d ready cycles expected 0", bad); else n_pass++;
    xfer(1, 0, 32'h1FFC, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
    bus_idle();
    n_checks++; if (rd !== 64'hCAFEF00D) $display("FAIL abort_nowrite: got %h expected cafef00d", rd); else n_pass++;
    @(posedge pclk); #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic err; int lat, bad;
    logic [31:0] addr;
    logic [63:0] keep;
    for (int t = 0; t < 2; t++) begin
      addr = (t == 0) ? 32'h1000 : 32'h1FFC;
      keep = (t == 0) ? 64'hDEADBEEF : 64'hCAFEF00D;
      cur = t;
      psel_v = 3'b000; psel_v[t] = 1'b1;
      penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = 64'h0; pstrb = 8'hF; pprot = 3'b000;
      @(posedge pclk); #1; penable = 1'b1;
      if (t == 1) begin @(posedge pclk); #1; end
      n_checks++; if (rdy_m !== (t == 0)) $display("FAIL rstmid_pre_ready t=%0d: got %b expected %0d", t, rdy_m, t == 0); else n_pass++;
      #2 presetn = 1'b0;
      #1;
      n_checks++; if (rdy_m !== 1'b0 || err_m !== 1'b0 || rd_m !== 64'd0)
        $display("FAIL rstmid_outputs t=%0d: got ready=%b err=%b data=%h expected all 0", t, rdy_m, err_m, rd_m);
      else n_pass++;
      @(posedge pclk); #1;
      presetn = 1'b1;
      bus_idle();
      @(posedge pclk); #1;
      xfer(t, 0, addr, 64'd0, 8'h0, 3'b000, rd, err, lat, bad);
      bus_idle();
      n_checks++; if (rd !== keep) $display("FAIL rstmid_nowrite t=%0d: got %h expected %h", t, rd, keep); else n_pass++;
      @(posedge pclk); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [9] = '{32'h0FFC, 32'h1000, 32'h1008, 32'h1010, 32'h1018,
                               32'h1FF0, 32'h1FF8, 32'h2000, 32'h2008};
    logic [63:0] rd, e_rd, wd; logic err; int lat, bad; bit e_err, e_known;
    int t; bit wr; logic [31:0] addr; logic [7:0] st; logic [2:0] pr;
    for (int ti = 0; ti < 3; ti++) begin
      for (int ai = 1; ai < 7; ai++) begin
        wd = {$urandom, $urandom};
        ref_model(ti, 1, addrs[ai], wd, 8'hFF, 3'b000, e_err, e_rd, e_known);
        xfer(ti, 1, addrs[ai], wd, 8'hFF, 3'b000, rd, err, lat, bad);
      end
    end
    for (int n = 0; n < 60; n++) begin
      t    = $urandom_range(0, 2);
      wr   = $urandom_range(0, 1);
      addr = addrs[$urandom_range(0, 8)];
      if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
      wd   = {$urandom, $urandom};
      st   = 8'($urandom);
      if (!wr && $urandom_range(0, 4) != 0) st = 8'h0;
      pr   = ($urandom_range(0, 3) == 0) ? 3'b010 : 3'b000;
      ref_model(t, wr, addr, wd, st, pr, e_err, e_rd, e_known);
      xfer(t, wr, addr, wd, st, pr, rd, err, lat, bad);
      n_checks++; if (err !== e_err) $display("FAIL rnd_err n=%0d: got %b expected %b", n, err, e_err); else n_pass++;
      n_checks++; if (lat != 2 + wsof(t) || bad != 0)
        $display("FAIL rnd_timing n=%0d: got cycles=%0d bad=%0d expected cycles=%0d bad=0", n, lat, bad, 2 + wsof(t));
      else n_pass++;
      if (!wr && e_known) begin
        n_checks++; if (rd !== e_rd) $display("FAIL rnd_rdata n=%0d: got %h expected %h", n, rd, e_rd); else n_pass++;
      end
      if ($urandom_range(0, 2) == 0) begin
        bus_idle();
        @(posedge pclk); #1;
      end
    end
    bus_idle();
    @(posedge pclk); #1;
  endtask

  initial begin
    cur = 0;
    test_reset();
    test_basic();
    test_partial_strobe();
    test_wait_states();
    test_errors();
    test_wide();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem_ws.md
Name: apb_slave_mem_ws

Overview:
- Parametrised APB4 completer backed by a byte-addressed memory window. Successor to the fixed 32-bit, zero-wait slave.
- Adds configurable data width, depth and base address, programmable wait states, and a proper setup/access state machine.
- Decodes range, alignment, strobe and protection errors into PSLVERR.
- Sits behind the AXI-to-APB bridge as one decoded slave.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 32 or 64.
- MEM_BYTES, 4096, window size in bytes; power of two, at least DATA_WIDTH/8.
- BASE_ADDR, 32'h0000_1000, first byte address of the window; aligned to MEM_BYTES.
- WAIT_STATES, 0, number of access-phase cycles with PREADY low before completion; range 0..15.
- SECURE_ONLY, 0, when 1, transfers with PPROT[1]=1 (non-secure) are rejected.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PPROT  in  3  protection attributes.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, wait counter=0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Memory contents are NOT reset (RAM inference); values before the first write are undefined.
- FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE/ACCESS -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> ACCESS on the next edge (PENABLE=1 expected).
  - ACCESS -> IDLE on the completing edge, unless the next transfer's setup is presented (see back-to-back).
- Setup edge (PSEL=1, PENABLE=0) captures: address offset (PADDR-BASE_ADDR), PWRITE, PSTRB, PPROT, error flag.
  - Wait counter is loaded with WAIT_STATES.
  - For reads, the read-data register is loaded from memory at the word offset. Error reads load 0.
- ACCESS while counter != 0:
  - PREADY=0, PSLVERR=0.
  - Counter decrements each edge.
- ACCESS with counter==0:
  - PREADY=1 (combinational from state/counter).
  - PSLVERR=error flag.
  - PRDATA=read-data register for reads; 0 for writes.
- Completing edge (PSEL & PENABLE & PREADY):
  - A write without error updates each byte i where PSTRB[i]=1: mem[offset+i]=PWDATA[8i+7:8i]. Other bytes are unchanged.
  - An error write modifies nothing.
- Zero-wait latency: PREADY=1 in the first access cycle, i.e. 2 cycles per transfer. Latency with wait states is 2+WAIT_STATES cycles.
- Error flag is the OR of:
  - PADDR < BASE_ADDR, or PADDR >= BASE_ADDR+MEM_BYTES.
  - PADDR[log2(DATA_WIDTH/8)-1:0] != 0 (misaligned).
  - Read with PSTRB != 0.
  - SECURE_ONLY=1 and PPROT[1]=1.
- PSLVERR is asserted only while PREADY=1 and is 0 otherwise.
- Error transfers still consume the full wait states.
- Offset arithmetic is ADDR_WIDTH bits; out-of-range offsets never index memory.
- Back-to-back: a setup presented on the cycle after completion is accepted; there is no idle cycle required.
- PSEL deasserted while in ACCESS with PREADY=0 is a protocol violation. Required response: abort, go to IDLE, write nothing, PREADY=0.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. A pending write is dropped.
- Outside ACCESS, PRDATA=0 and PREADY=0.

Test Plan:
- Reset, WAIT_STATES=0: write 0xDEADBEEF @0x1000, PSTRB=4'hF, then read @0x1000 -> PREADY high in each first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0, 2 cycles per transfer.
- Partial strobe: write 0x11223344 @0x1004 (PSTRB=F), then write 0xAABBCCDD with PSTRB=4'b0101, then read -> PRDATA=0x11BB33DD.
- WAIT_STATES=3: read @0x1FFC -> PREADY low for exactly 3 access cycles, high on the 4th; 5 cycles total.
- Errors:
  - Read @0x2000 -> PSLVERR=1, PRDATA=0.
  - Write @0x1002 -> PSLVERR=1, and mem@0x1000 is unchanged on readback.
  - Read with PSTRB=4'h1 -> PSLVERR=1.
  - SECURE_ONLY=1, PPROT=3'b010 write -> PSLVERR=1, no write.
- DATA_WIDTH=64: write 0x0123456789ABCDEF @0x1008, PSTRB=8'hF0 -> readback upper 32 bits 0x01234567, lower bits unchanged. Address 0x1004 -> misaligned error.
- Robustness:
  - Back-to-back write then read to the same address with no idle cycle -> read returns the new data.
  - PRESETn low during a wait-state write -> outputs 0 immediately, memory unchanged.
